// File: rtl/qeciphy_tx_arbiter.sv
// Two-source arbiter into a 2-entry {tag, data} FIFO; a word is at the head one cycle after acceptance.
// Source ready depends on registered FIFO occupancy, so i_tx_ready never reaches it combinationally.
module qeciphy_tx_arbiter #(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic              tx_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_s0_data,
    input  logic              i_s0_valid,
    output logic              o_s0_ready,
    input  logic [DATA_W-1:0] i_s1_data,
    input  logic              i_s1_valid,
    output logic              o_s1_ready,
    input  logic              i_enable,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_tx_src,
    output logic [15:0]       o_s0_words,
    output logic [15:0]       o_s1_words
);
    typedef struct packed {
        logic              src;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t      head;
    entry_t      tail;
    entry_t      push_ent;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        owner;
    logic [3:0]  burst_cnt;
    logic        sat;
    logic        grant;
    logic        space;
    logic        push;
    logic        pop;

    assign sat = (burst_cnt == 4'(MAX_BURST));

    // The owner keeps the grant until its burst saturates, and only loses it if the other side is waiting.
    always_comb begin
        grant = owner;
        if (i_s0_valid && !i_s1_valid) begin
            grant = 1'b0;
        end else if (i_s1_valid && !i_s0_valid) begin
            grant = 1'b1;
        end else if (i_s0_valid && i_s1_valid && sat) begin
            grant = ~owner;
        end
    end

    assign space      = !rst && i_enable && (count != 2'd2);
    assign o_s0_ready = space && !grant;
    assign o_s1_ready = space && grant;
    assign push       = (o_s0_ready && i_s0_valid) || (o_s1_ready && i_s1_valid);
    assign pop        = o_tx_valid && i_tx_ready;
    assign push_ent   = {grant, (grant ? i_s1_data : i_s0_data)};
    assign count_next = count + 2'(push) - 2'(pop);

    assign o_tx_data = head.data;
    assign o_tx_src  = head.src;

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            count      <= 2'd0;
            o_tx_valid <= 1'b0;
            head       <= '0;
            tail       <= '0;
        end else begin
            count      <= count_next;
            o_tx_valid <= (count_next != 2'd0);
            // Push with pop only happens at count 1, so the new word goes straight to the head.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_ent;
                    end else begin
                        tail <= push_ent;
                    end
                end
                2'b01:   head <= tail;
                2'b11:   head <= push_ent;
                default: ;
            endcase
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            owner      <= 1'b0;
            burst_cnt  <= 4'd0;
            o_s0_words <= 16'd0;
            o_s1_words <= 16'd0;
        end else if (push) begin
            if (grant == owner) begin
                if (!sat) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else begin
                owner     <= grant;
                burst_cnt <= 4'd1;
            end
            if (grant) begin
                o_s1_words <= o_s1_words + 16'd1;
            end else begin
                o_s0_words <= o_s0_words + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_qeciphy_tx_arbiter.sv
// Randomised and directed bench for qeciphy_tx_arbiter against a queue-based reference model.
module tb_qeciphy_tx_arbiter;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 4;

    logic              tx_clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s0_data;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] tx_data;
    logic              s0_valid;
    logic              s1_valid;
    logic              s0_ready;
    logic              s1_ready;
    logic              enable;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_src;
    logic [15:0]       s0_words;
    logic [15:0]       s1_words;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted words in order, arbitration state, per-source counts.
    logic [DATA_W:0] mq[$];
    bit  m_owner = 1'b0;
    int  m_burst = 0;
    int  m_w0    = 0;
    int  m_w1    = 0;
    bit  m_ok    = 1'b0;
    bit  tags[$];
    bit  exp_tags[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DATA_W-1:0] pat_a = 64'hAAAA_AAAA_AAAA_AA01;

    qeciphy_tx_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .tx_clk     (tx_clk),
        .rst        (rst),
        .i_s0_data  (s0_data),
        .i_s0_valid (s0_valid),
        .o_s0_ready (s0_ready),
        .i_s1_data  (s1_data),
        .i_s1_valid (s1_valid),
        .o_s1_ready (s1_ready),
        .i_enable   (enable),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_tx_src   (tx_src),
        .o_s0_words (s0_words),
        .o_s1_words (s1_words)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluated at the falling edge: compare, then advance the model to the post-edge state.
    task automatic model_step();
        int sz;
        bit space;
        bit g;
        bit acc;
        bit pop;
        sz    = mq.size();
        space = !rst && enable && (sz < 2);
        if (s0_valid && !s1_valid)                             g = 1'b0;
        else if (s1_valid && !s0_valid)                        g = 1'b1;
        else if (s0_valid && s1_valid && m_burst == MAX_BURST) g = !m_owner;
        else                                                   g = m_owner;
        chk("s0_ready", 64'(s0_ready), 64'(space && !g));
        chk("s1_ready", 64'(s1_ready), 64'(space && g));
        if (rst) begin
            mq.delete();
            m_owner = 1'b0;
            m_burst = 0;
            m_w0    = 0;
            m_w1    = 0;
            m_ok    = 1'b1;
            return;
        end
        if (!m_ok) return;
        chk("tx_valid", 64'(tx_valid), 64'(sz > 0));
        if (sz > 0) begin
            chk("tx_data", tx_data, mq[0][DATA_W-1:0]);
            chk("tx_src", 64'(tx_src), 64'(mq[0][DATA_W]));
        end
        chk("s0_words", 64'(s0_words), 64'(m_w0));
        chk("s1_words", 64'(s1_words), 64'(m_w1));
        if (tx_valid && tx_ready) tags.push_back(tx_src);
        pop = (sz > 0) && tx_ready;
        acc = space && (g ? s1_valid : s0_valid);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back({g, (g ? s1_data : s0_data)});
            if (g == m_owner) begin
                if (m_burst < MAX_BURST) m_burst++;
            end else begin
                m_owner = g;
                m_burst = 1;
            end
            if (g) m_w1 = (m_w1 + 1) % 65536;
            else   m_w0 = (m_w0 + 1) % 65536;
        end
    endtask

    task automatic cyc();
        @(negedge tx_clk);
        model_step();
        @(posedge tx_clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_tx_src", 64'(tx_src), 64'd0);
        chk("rst_s0_words", 64'(s0_words), 64'd0);
        chk("rst_s1_words", 64'(s1_words), 64'd0);

        // Single word from source 0.
        enable = 1'b1; tx_ready = 1'b1; s0_valid = 1'b1; s0_data = pat_a;
        #1;
        chk("first_s0_ready", 64'(s0_ready), 64'd1);
        cyc();
        s0_valid = 1'b0;
        chk("first_tx_valid", 64'(tx_valid), 64'd1);
        chk("first_tx_data", tx_data, 64'hAAAA_AAAA_AAAA_AA01);
        chk("first_tx_src", 64'(tx_src), 64'd0);
        chk("first_s0_words", 64'(s0_words), 64'd1);
        cyc();

        // Both sources contending: bursts of MAX_BURST alternate.
        rst = 1'b1; cyc(); rst = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1; tx_ready = 1'b1;
        tags.delete();
        repeat (10) begin
            s0_data = rnd64(); s1_data = rnd64();
            cyc();
        end
        chk("burst_tag_count", 64'(tags.size()), 64'd9);
        for (int i = 0; i < 9 && i < tags.size(); i++)
            chk($sformatf("burst_tag%0d", i), 64'(tags[i]), 64'(exp_tags[i]));

        // Source 1 streaming through a 3-cycle output stall.
        s0_valid = 1'b0;
        repeat (3) begin s1_data = rnd64(); cyc(); end
        tx_ready = 1'b0;
        repeat (3) begin s1_data = rnd64(); cyc(); end
        chk("stall_s1_ready", 64'(s1_ready), 64'd0);
        chk("stall_tx_valid", 64'(tx_valid), 64'd1);
        tx_ready = 1'b1;
        repeat (5) begin s1_data = rnd64(); cyc(); end

        // Drain with enable low.
        s1_valid = 1'b0;
        repeat (3) cyc();
        tx_ready = 1'b0; s0_valid = 1'b1;
        repeat (2) begin s0_data = rnd64(); cyc(); end
        enable = 1'b0; tx_ready = 1'b1; s1_valid = 1'b1;
        #1;
        chk("dis_s0_ready", 64'(s0_ready), 64'd0);
        chk("dis_s1_ready", 64'(s1_ready), 64'd0);
        cyc(); cyc();
        chk("dis_tx_valid", 64'(tx_valid), 64'd0);

        // Reset with the FIFO full.
        enable = 1'b1; tx_ready = 1'b0;
        repeat (2) begin s0_data = rnd64(); s1_data = rnd64(); cyc(); end
        rst = 1'b1;
        #1;
        chk("rst_hi_s0_ready", 64'(s0_ready), 64'd0);
        chk("rst_hi_s1_ready", 64'(s1_ready), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("full_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("full_rst_s0_words", 64'(s0_words), 64'd0);
        chk("full_rst_s1_words", 64'(s1_words), 64'd0);
        chk("full_rst_owner0", 64'(s0_ready), 64'd1);

        // Randomised traffic.
        repeat (3000) begin
            rst      = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            s0_valid = ($urandom_range(0, 2) != 0);
            s1_valid = ($urandom_range(0, 2) != 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            s0_data  = rnd64();
            s1_data  = rnd64();
            cyc();
        end

        // Counter wrap: 65537 transfers leave 1.
        rst = 1'b1; cyc(); rst = 1'b0;
        enable = 1'b1; tx_ready = 1'b1; s0_valid = 1'b1; s1_valid = 1'b0;
        repeat (65537) begin s0_data = rnd64(); cyc(); end
        s0_valid = 1'b0;
        chk("wrap_s0_words", 64'(s0_words), 64'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
